// File: rtl/yuv_stream_arbiter.sv
// Packet round-robin arbiter feeding one YUV422->444 converter.
// A 2-entry skid buffer decouples s_tready from m_tready.
module yuv_stream_arbiter #(
  parameter int N_SRC      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          arb_en,
  input  logic [N_SRC-1:0]              s_tvalid,
  output logic [N_SRC-1:0]              s_tready,
  input  logic [N_SRC*DATA_WIDTH-1:0]   s_tdata,
  input  logic [N_SRC*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [N_SRC*DATA_WIDTH/8-1:0] s_tstrb,
  input  logic [N_SRC-1:0]              s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_tkeep,
  output logic [DATA_WIDTH/8-1:0]       m_tstrb,
  output logic                          m_tlast,
  output logic [DEST_WIDTH-1:0]         m_tdest,
  output logic                          busy,
  output logic [DEST_WIDTH-1:0]         grant_id
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + 2 * KW + 1 + DEST_WIDTH;

  if (DEST_WIDTH < $clog2(N_SRC)) begin : g_bad_dest
    $error("DEST_WIDTH too small for N_SRC");
  end

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEST_WIDTH-1:0] r_grant;
  logic [DEST_WIDTH-1:0] w_grant_nxt;
  logic                  w_found;
  logic [1:0]            r_cnt;
  logic [EW-1:0]         r_mem0;
  logic [EW-1:0]         r_mem1;
  logic [EW-1:0]         w_in;
  logic                  w_rdy;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid_g;
  logic                  w_last_g;
  logic [DATA_WIDTH-1:0] w_data_g;
  logic [KW-1:0]         w_keep_g;
  logic [KW-1:0]         w_strb_g;

  // ready comes only from registered state, never from m_tready
  assign w_rdy = (r_state == LOCKED) && (r_cnt != 2'd2);

  always_comb begin
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_data_g  = '0;
    w_keep_g  = '0;
    w_strb_g  = '0;
    s_tready  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == DEST_WIDTH'(i)) begin
        w_valid_g   = s_tvalid[i];
        w_last_g    = s_tlast[i];
        w_data_g    = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_keep_g    = s_tkeep[i*KW +: KW];
        w_strb_g    = s_tstrb[i*KW +: KW];
        s_tready[i] = w_rdy;
      end
    end
  end

  assign w_push = w_rdy && w_valid_g;
  assign w_pop  = (r_cnt != 2'd0) && m_tready;
  assign w_in   = {w_data_g, w_keep_g, w_strb_g, w_last_g, r_grant};

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_found     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (arb_en && |s_tvalid) begin
          // search starts just past the last winner
          for (int k = 1; k <= N_SRC; k++) begin
            for (int i = 0; i < N_SRC; i++) begin
              if (!w_found && s_tvalid[i] &&
                  ((int'(r_grant) + k) % N_SRC == i)) begin
                w_grant_nxt = DEST_WIDTH'(i);
                w_found     = 1'b1;
              end
            end
          end
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_push && w_last_g) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_grant <= DEST_WIDTH'(N_SRC - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      if (w_push && w_pop) begin
        r_mem0 <= w_in;
      end else if (w_push) begin
        if (r_cnt == 2'd0) begin
          r_mem0 <= w_in;
        end else begin
          r_mem1 <= w_in;
        end
        r_cnt <= r_cnt + 2'd1;
      end else if (w_pop) begin
        r_mem0 <= r_mem1;
        r_cnt  <= r_cnt - 2'd1;
      end
    end
  end

  assign {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tdest} = r_mem0;
  assign m_tvalid = (r_cnt != 2'd0);
  assign busy     = (r_state == LOCKED);
  assign grant_id = r_grant;

endmodule

// File: tb/tb_yuv_stream_arbiter.sv
// Directed bench for yuv_stream_arbiter: cycle table plus
// hand-written multi-cycle sequences on a 2- and a 4-source instance.
module tb_yuv_stream_arbiter;

  logic         aclk;
  logic         aresetn;
  logic         arb_en;
  logic [1:0]   s_tvalid;
  logic [1:0]   s_tready;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [15:0]  s_tstrb;
  logic [1:0]   s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic [7:0]   m_tstrb;
  logic         m_tlast;
  logic [0:0]   m_tdest;
  logic         busy;
  logic [0:0]   grant_id;

  logic [3:0]   s4_tvalid;
  logic [3:0]   s4_tready;
  logic [63:0]  s4_tdata;
  logic [7:0]   s4_tkeep;
  logic [7:0]   s4_tstrb;
  logic [3:0]   s4_tlast;
  logic         m4_tvalid;
  logic [15:0]  m4_tdata;
  logic [1:0]   m4_tkeep;
  logic [1:0]   m4_tstrb;
  logic         m4_tlast;
  logic [1:0]   m4_tdest;
  logic         busy4;
  logic [1:0]   grant4;

  yuv_stream_arbiter #(
    .N_SRC(2), .DATA_WIDTH(64), .DEST_WIDTH(1)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .arb_en(arb_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .busy(busy), .grant_id(grant_id)
  );

  yuv_stream_arbiter #(
    .N_SRC(4), .DATA_WIDTH(16), .DEST_WIDTH(2)
  ) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .arb_en(1'b1),
    .s_tvalid(s4_tvalid), .s_tready(s4_tready),
    .s_tdata(s4_tdata), .s_tkeep(s4_tkeep),
    .s_tstrb(s4_tstrb), .s_tlast(s4_tlast),
    .m_tvalid(m4_tvalid), .m_tready(1'b1),
    .m_tdata(m4_tdata), .m_tkeep(m4_tkeep),
    .m_tstrb(m4_tstrb), .m_tlast(m4_tlast),
    .m_tdest(m4_tdest), .busy(busy4), .grant_id(grant4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        vld;
    logic [63:0] dat;
    logic        lst;
    logic        e_mv;
    logic [63:0] e_md;
    logic        e_ml;
    logic [1:0]  e_sr;
  } vec_t;

  vec_t tv[7];

  int npass = 0;
  int ntot  = 0;

  int s_len[2];
  int s_beat[2];
  int s_pkt[2];
  int s_npkt[2];
  logic [1:0] r_hs;

  logic [63:0] q_data[$];
  logic        q_last[$];
  logic [0:0]  q_dest[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = (s_npkt[i] > 0);
      s_tdata[i*64 +: 64] = 64'(i * 4096 + s_pkt[i] * 16 + s_beat[i]);
      s_tlast[i] = (s_beat[i] == s_len[i] - 1);
    end
    s_tkeep = 16'hFFFF;
    s_tstrb = 16'hFFFF;
  endtask

  task automatic model_init();
    for (int i = 0; i < 2; i++) begin
      s_len[i]  = 1;
      s_beat[i] = 0;
      s_pkt[i]  = 0;
      s_npkt[i] = 0;
    end
    r_hs = 2'b00;
    q_data.delete();
    q_last.delete();
    q_dest.delete();
  endtask

  task automatic sample_neg();
    @(negedge aclk);
    r_hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_last.push_back(m_tlast);
      q_dest.push_back(m_tdest);
    end
  endtask

  task automatic adv();
    @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r_hs[i]) begin
        if (s_beat[i] == s_len[i] - 1) begin
          s_beat[i] = 0;
          s_pkt[i]++;
          s_npkt[i]--;
        end else begin
          s_beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic cyc();
    sample_neg();
    adv();
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    arb_en   = 1'b1;
    m_tready = 1'b1;
    model_init();
    drive();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int n;
    logic [63:0] held;
    int g4[$];
    int d4[$];
    logic pb;

    tv[0] = '{1'b1, 64'h10, 1'b0, 1'b0, 64'h0,  1'b0, 2'b00};
    tv[1] = '{1'b1, 64'h10, 1'b0, 1'b0, 64'h0,  1'b0, 2'b01};
    tv[2] = '{1'b1, 64'h11, 1'b0, 1'b1, 64'h10, 1'b0, 2'b01};
    tv[3] = '{1'b1, 64'h12, 1'b0, 1'b1, 64'h11, 1'b0, 2'b01};
    tv[4] = '{1'b1, 64'h13, 1'b1, 1'b1, 64'h12, 1'b0, 2'b01};
    tv[5] = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h13, 1'b1, 2'b00};
    tv[6] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b0, 2'b00};

    s4_tvalid = '0;
    s4_tdata  = '0;
    s4_tkeep  = '0;
    s4_tstrb  = '0;
    s4_tlast  = '0;
    aresetn   = 1'b0;
    arb_en    = 1'b1;
    m_tready  = 1'b1;
    model_init();
    drive();
    s_tvalid = '0;

    // reset state
    #13;
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_sready", 64'(s_tready), 64'd0);
    chk("rst_busy",   64'(busy),     64'd0);
    chk("rst_grant",  64'(grant_id), 64'd1);
    chk("rst_mdata",  m_tdata,       64'd0);
    chk("rst_grant4", 64'(grant4),   64'd3);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // test 1: single 4-beat packet, cycle table
    for (int r = 0; r < 7; r++) begin
      s_tvalid = {1'b0, tv[r].vld};
      s_tdata  = {64'h0, tv[r].dat};
      s_tlast  = {1'b0, tv[r].lst};
      s_tkeep  = {8'h00, 8'hFF};
      s_tstrb  = {8'h00, 8'h0F};
      @(negedge aclk);
      chk($sformatf("t1_sready[%0d]", r), 64'(s_tready), 64'(tv[r].e_sr));
      chk($sformatf("t1_mvalid[%0d]", r), 64'(m_tvalid), 64'(tv[r].e_mv));
      if (tv[r].e_mv) begin
        chk($sformatf("t1_mdata[%0d]", r), m_tdata, tv[r].e_md);
        chk($sformatf("t1_mlast[%0d]", r), 64'(m_tlast), 64'(tv[r].e_ml));
        chk($sformatf("t1_mdest[%0d]", r), 64'(m_tdest), 64'd0);
        chk($sformatf("t1_mstrb[%0d]", r), 64'(m_tstrb), 64'h0F);
      end
      @(posedge aclk);
      #1;
    end

    // test 2: two sources with 2-beat packets alternate
    do_reset();
    s_len[0] = 2; s_npkt[0] = 2;
    s_len[1] = 2; s_npkt[1] = 2;
    drive();
    n = 0;
    while (q_data.size() < 8 && n < 100) begin cyc(); n++; end
    chk("t2_timeout", 64'(q_data.size() >= 8), 64'd1);
    for (int k = 0; k < 8 && k < q_data.size(); k++) begin
      chk($sformatf("t2_dest[%0d]", k), 64'(q_dest[k]), 64'((k / 2) % 2));
      chk($sformatf("t2_data[%0d]", k), q_data[k],
          64'(((k / 2) % 2) * 4096 + (k / 4) * 16 + k % 2));
      chk($sformatf("t2_last[%0d]", k), 64'(q_last[k]), 64'(k % 2));
    end

    // test 3: output stall mid-packet
    do_reset();
    s_len[0] = 6; s_npkt[0] = 1;
    drive();
    n = 0;
    while (q_data.size() < 1 && n < 50) begin cyc(); n++; end
    chk("t3_start_timeout", 64'(q_data.size()), 64'd1);
    m_tready = 1'b0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      sample_neg();
      if (k == 0) held = m_tdata;
      else chk($sformatf("t3_hold[%0d]", k), m_tdata, held);
      chk($sformatf("t3_hvalid[%0d]", k), 64'(m_tvalid), 64'd1);
      if (k == 4) chk("t3_sready_full", 64'(s_tready), 64'd0);
      adv();
    end
    chk("t3_held_val", held, 64'd1);
    m_tready = 1'b1;
    n = 0;
    while (q_data.size() < 6 && n < 50) begin cyc(); n++; end
    repeat (5) cyc();
    chk("t3_count", 64'(q_data.size()), 64'd6);
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      chk($sformatf("t3_data[%0d]", k), q_data[k], 64'(k));
      chk($sformatf("t3_last[%0d]", k), 64'(q_last[k]), 64'(k == 5));
    end

    // test 4: arb_en dropped mid-packet
    do_reset();
    s_len[1] = 3; s_npkt[1] = 1;
    drive();
    n = 0;
    while (s_beat[1] != 1 && n < 50) begin cyc(); n++; end
    chk("t4_beat_timeout", 64'(s_beat[1]), 64'd1);
    arb_en = 1'b0;
    s_len[0] = 1; s_npkt[0] = 1;
    drive();
    n = 0;
    while (q_data.size() < 3 && n < 50) begin cyc(); n++; end
    for (int k = 0; k < 4; k++) begin
      sample_neg();
      chk($sformatf("t4_hold_busy[%0d]", k), 64'(busy), 64'd0);
      chk($sformatf("t4_hold_rdy[%0d]", k), 64'(s_tready), 64'd0);
      adv();
    end
    arb_en = 1'b1;
    sample_neg();
    chk("t4_arb_cycle_busy", 64'(busy), 64'd0);
    adv();
    sample_neg();
    chk("t4_grant_busy", 64'(busy), 64'd1);
    chk("t4_grant_id",   64'(grant_id), 64'd0);
    adv();
    n = 0;
    while (q_data.size() < 4 && n < 50) begin cyc(); n++; end
    chk("t4_count", 64'(q_data.size()), 64'd4);
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      chk($sformatf("t4_dest[%0d]", k), 64'(q_dest[k]), 64'(k < 3 ? 1 : 0));
      chk($sformatf("t4_data[%0d]", k), q_data[k],
          64'(k < 3 ? 4096 + k : 0));
      chk($sformatf("t4_last[%0d]", k), 64'(q_last[k]), 64'(k >= 2));
    end

    // test 5: async reset with two beats buffered
    do_reset();
    m_tready = 1'b0;
    s_len[0] = 6; s_npkt[0] = 1;
    drive();
    n = 0;
    sample_neg();
    while (!(busy && s_tready == 2'b00 && m_tvalid) && n < 50) begin
      adv();
      sample_neg();
      n++;
    end
    chk("t5_fill_timeout", 64'(n < 50), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t5_mvalid", 64'(m_tvalid), 64'd0);
    chk("t5_sready", 64'(s_tready), 64'd0);
    chk("t5_grant",  64'(grant_id), 64'd1);
    chk("t5_busy",   64'(busy),     64'd0);
    model_init();
    m_tready = 1'b1;
    drive();
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    s_len[0] = 1; s_npkt[0] = 1;
    s_len[1] = 1; s_npkt[1] = 1;
    drive();
    n = 0;
    sample_neg();
    while (!busy && n < 20) begin adv(); sample_neg(); n++; end
    chk("t5_first_grant", 64'(grant_id), 64'd0);
    adv();
    n = 0;
    while (q_data.size() < 2 && n < 50) begin cyc(); n++; end
    chk("t5_count", 64'(q_data.size()), 64'd2);
    if (q_data.size() >= 2) begin
      chk("t5_dest0", 64'(q_dest[0]), 64'd0);
      chk("t5_dest1", 64'(q_dest[1]), 64'd1);
    end

    // test 6: four sources, only 2 and 3 request
    do_reset();
    s4_tvalid = 4'b1100;
    s4_tlast  = 4'b1111;
    s4_tdata  = {16'hBB33, 16'hAA22, 16'h0, 16'h0};
    s4_tkeep  = 8'hFF;
    s4_tstrb  = {2'b01, 2'b10, 4'b0};
    pb = 1'b0;
    n = 0;
    while ((g4.size() < 4 || d4.size() < 4) && n < 60) begin
      @(negedge aclk);
      if (busy4 && !pb && g4.size() < 4) g4.push_back(int'(grant4));
      if (m4_tvalid && d4.size() < 4) begin
        if (d4.size() == 0) begin
          chk("t6_data0", 64'(m4_tdata), 64'hAA22);
          chk("t6_kslt0", 64'({m4_tkeep, m4_tstrb, m4_tlast}), 64'b11101);
        end
        d4.push_back(int'(m4_tdest));
      end
      pb = busy4;
      n++;
    end
    chk("t6_timeout", 64'(g4.size() == 4 && d4.size() == 4), 64'd1);
    for (int k = 0; k < 4 && k < g4.size(); k++)
      chk($sformatf("t6_grant[%0d]", k), 64'(g4[k]), 64'(k % 2 == 0 ? 2 : 3));
    for (int k = 0; k < 4 && k < d4.size(); k++)
      chk($sformatf("t6_dest[%0d]", k), 64'(d4[k]), 64'(k % 2 == 0 ? 2 : 3));
    s4_tvalid = '0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
